// File: rtl/nibble_sequencer.sv
// nibble_sequencer: streams a wide add/sub through a 4-bit arithmetic unit, LSB nibble first.
// Optional result saturation on signed overflow when NIBBLE_SEQ_SAT_EN is defined.
module nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 op,
    input  logic [4*NIBBLES-1:0] operandA,
    input  logic [4*NIBBLES-1:0] operandB,
    input  logic                 carryIn,
    output logic [1:0]           opCode,
    output logic [3:0]           A,
    output logic [3:0]           B,
    output logic                 CarryIN,
    input  logic [3:0]           add_Y,
    input  logic [3:0]           sub_Y,
    input  logic                 CarryOUT,
    input  logic                 overflow,
    output logic [4*NIBBLES-1:0] result,
    output logic                 resultCarry,
    output logic                 resultOverflow,
    output logic                 resultZero,
    output logic                 result_valid,
    input  logic                 result_ready
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, nextState;
    logic [W-1:0]    opA, opB, assembled, finalRes;
    logic [IW-1:0]   idx;
    logic            isSub, cy, lastNibble, ovfNow;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nextState;

    always_comb begin
        nextState = state;
        if (state == IDLE && start_valid)       nextState = RUN;
        else if (state == RUN && lastNibble)    nextState = DONE;
        else if (state == DONE && result_ready) nextState = IDLE;
    end

    always_comb begin
        start_ready  = state == IDLE;
        result_valid = state == DONE;
        opCode       = state == RUN ? (isSub ? 2'b10 : 2'b01) : 2'b00;
        A            = state == RUN ? opA[4*idx +: 4] : 4'h0;
        B            = state == RUN ? opB[4*idx +: 4] : 4'h0;
        CarryIN      = state == RUN ? cy : 1'b0;
    end

    assign lastNibble = idx == IW'(NIBBLES - 1);
    // Subtract overflow is derived here because the unit only reports it for add.
    assign ovfNow = isSub ? (A[3] != B[3]) && (sub_Y[3] != A[3]) : overflow;

    always_comb begin
        assembled              = result;
        assembled[4*idx +: 4]  = add_Y | sub_Y;
    end

`ifdef NIBBLE_SEQ_SAT_EN
    assign finalRes = ovfNow ? (opA[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : assembled;
`else
    assign finalRes = assembled;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA            <= '0;
            opB            <= '0;
            isSub          <= 1'b0;
            idx            <= '0;
            cy             <= 1'b0;
            result         <= '0;
            resultCarry    <= 1'b0;
            resultOverflow <= 1'b0;
            resultZero     <= 1'b0;
        end else if (state == IDLE && start_valid) begin
            opA   <= operandA;
            opB   <= operandB;
            isSub <= op;
            idx   <= '0;
            cy    <= carryIn;
        end else if (state == RUN) begin
            idx    <= idx + 1'b1;
            cy     <= CarryOUT;
            result <= lastNibble ? finalRes : assembled;
            if (lastNibble) begin
                resultCarry    <= CarryOUT;
                resultOverflow <= ovfNow;
                resultZero     <= finalRes == '0;
            end
        end
    end
endmodule

// File: doc/nibble_sequencer.md
# nibble_sequencer

Multi-precision front-end for the 4-bit arithmetic unit. Accepts a wide add/subtract request over a valid/ready handshake, then drives the unit's `opCode`, `A`, `B` and `CarryIN` one nibble per cycle, LSB nibble first, chaining carry/borrow. It collects `add_Y`/`sub_Y`, `CarryOUT` and `overflow` into a wide result with flags. It sits directly upstream and downstream of the arithmetic unit, and the unit stays purely combinational.

## Interface
- `NIBBLES`, 4, operand width in nibbles (W = 4*NIBBLES); legal range 2..8
- `clk` in 1, rising-edge clock
- `rst_n` in 1, reset, asynchronous, active-low
- `start_valid` in 1, request valid
- `start_ready` out 1, request accepted when both high at a rising edge
- `op` in 1, 0 = add, 1 = subtract
- `operandA` in W, first operand (minuend for subtract)
- `operandB` in W, second operand (subtrahend)
- `carryIn` in 1, initial carry-in (add) or borrow-in (subtract)
- `opCode` out 2, to the unit: 2'b01 add, 2'b10 sub, 2'b00 idle
- `A` out 4, current nibble of operandA to the unit
- `B` out 4, current nibble of operandB to the unit
- `CarryIN` out 1, chained carry/borrow to the unit
- `add_Y` in 4, from the unit
- `sub_Y` in 4, from the unit
- `CarryOUT` in 1, from the unit
- `overflow` in 1, from the unit (add only)
- `result` out W, final sum/difference
- `resultCarry` out 1, final carry-out or borrow-out
- `resultOverflow` out 1, signed overflow
- `resultZero` out 1, result == 0
- `result_valid` out 1, result available
- `result_ready` in 1, result consumed when both high at a rising edge

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start_ready` = 1.
  - On accept: latch operandA, operandB, op and carryIn; set nibble index `idx` = 0 and carry register `cy` = carryIn; go to RUN.
- **RUN**
  - Drive `opCode` per op, `A` = operandA[4*idx+3:4*idx], `B` likewise, `CarryIN` = cy.
  - Each edge: result nibble idx <= (add_Y | sub_Y); cy <= CarryOUT; idx++.
  - When idx == NIBBLES-1, also capture flags and go to DONE.
- **Flags**, captured at the last nibble:
  - resultCarry = CarryOUT.
  - Add: resultOverflow = unit `overflow`.
  - Sub: resultOverflow = (A[3] != B[3]) && (sub_Y[3] != A[3]), computed locally.
  - resultZero = (final result == 0), evaluated after the optional saturation.
- **DONE**
  - `result_valid` = 1; result and flags held stable.
  - On `result_ready` go to IDLE. `start_ready` is 0 here, so there are no back-to-back requests.
- Outside RUN: `opCode` = 2'b00 and `A`, `B`, `CarryIN` = 0, so the unit's outputs are zero.
- Inputs `operandA`, `operandB`, `op` and `carryIn` are ignored except at accept.
- Reset values: state IDLE; `start_ready` 1; `result_valid` 0; result and all flags 0; `opCode`, `A`, `B`, `CarryIN` 0; idx 0; cy 0.
- Reset mid-operation: asynchronous clear to the reset values and the in-flight request is discarded. After `rst_n` rises, `start_ready` = 1 on the first edge.

## Timing
- Accept at edge T0; RUN spans the cycles between edges T0 and T0+NIBBLES.
- `result_valid` rises after edge T0+NIBBLES (latency NIBBLES cycles) and stays high until the `result_ready` handshake.
- `start_ready` returns high the cycle after the result handshake. Peak throughput is one request per NIBBLES+2 cycles.
- Unit outputs are sampled in the same cycle its inputs are driven; the unit's combinational delay must fit in one clock period.
- `start_valid` held high while in RUN or DONE has no effect.

## Configuration
- Macro: `NIBBLE_SEQ_SAT_EN`.
- **Defined:** when resultOverflow = 1, `result` is clamped.
  - Clamp to 0x7F…F if operandA's sign bit is 0, otherwise to 0x80…0.
  - resultOverflow still reads 1; resultCarry is unchanged.
- **Undefined:** `result` is the wrapped two's-complement value and no saturation logic is present.

## Test plan
- Add 0x1234 + 0x0FCD, carryIn 0 -> result 0x2201, carry 0, ovf 0, zero 0. `result_valid` exactly 4 cycles after accept. `opCode` reads 01 during those 4 cycles only.
- Add 0xFFFF + 0x0001 -> result 0x0000, carry 1, ovf 0, zero 1.
- Sub 0x0000 - 0x0001, carryIn 0 -> result 0xFFFF, borrow 1, ovf 0, zero 0.
- Add 0x7FFF + 0x0001 -> ovf 1. Result 0x8000 without the macro, 0x7FFF with it. Sub 0x8000 - 0x0001 -> ovf 1. Result 0x7FFF without the macro, 0x8000 with it.
- Hold `result_ready` low 3 cycles in DONE -> result and flags stable and `start_ready` stays 0. Pulse `start_valid` during RUN -> request not accepted.
- Drop `rst_n` on the 2nd RUN cycle -> all outputs 0 and `start_ready` 1 immediately. A new add 0x0001 + 0x0001 after release -> result 0x0002.
